// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg
// Shared geometry and state encoding for the burst memory responder.
// A line is 256 bits, moved as 4 beats of 64 bits; byte address bits
// [4:0] select a byte within a line and are ignored by the responder.
package burst_mem_pkg;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_t;

endpackage

// File: rtl/burst_mem_responder_if.sv
// burst_mem_responder_if
// Burst memory port between an initiator (cache) and a responder (memory).
//   mem_read / mem_write : request, held until the last beat is accepted
//   mem_addr             : byte address of the line
//   mem_wdata            : write beat, advanced after each mem_resp cycle
//   mem_rdata            : read beat, valid only while mem_resp is high
//   mem_resp             : beat strobe, 4 consecutive cycles per transaction
interface burst_mem_responder_if;
  import burst_mem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/burst_mem_array.sv
// burst_mem_array
// Line storage: DEPTH_LINES x LINE_W, one shared address, synchronous
// write and asynchronous read. Contents survive reset on purpose.
//   clk   : write clock
//   we    : write whole line at addr on the rising edge
//   addr  : line index for both read and write
//   wdata : line to store
//   rdata : line currently stored at addr
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH_LINES];

  // Whole-line write only; there is no partial-line write path.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder
// Memory-side responder for the 4-beat x 64-bit burst port. Accepts one
// read or write, waits LATENCY cycles, then streams or absorbs one line
// as 4 back-to-back beats, followed by one quiet DONE cycle.
//   clk     : clock, posedge
//   reset_n : asynchronous active-low reset (array contents kept)
//   bus     : burst port, responder side
//   err     : sticky protocol error (both requests at once, or request
//             dropped while a transaction is in flight)
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LATENCY     = 8,
  parameter int DEPTH_LINES = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  burst_mem_responder_if.slave        bus,
  output logic                        err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic [1:0]        beat_q, beat_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              is_wr_q, is_wr_d;
  logic [LINE_W-1:0] stage_q, stage_d;
  logic              resp_q, resp_d;
  logic [BEAT_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [LINE_W-1:0] line_rd;
  logic              req_dropped;

  burst_mem_array #(
    .DEPTH_LINES (DEPTH_LINES)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (stage_d),
    .rdata (line_rd)
  );

  // The initiator must hold the request it was accepted with until DONE.
  assign req_dropped = is_wr_q ? !bus.mem_write : !bus.mem_read;

  // Next-state logic. mem_resp and mem_rdata are computed one cycle ahead
  // so they come straight from flops; rdata_d defaults to zero so the read
  // bus is quiet whenever no beat is being presented. The array write uses
  // stage_d so beat 3 lands in the same edge as the commit.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    is_wr_d = is_wr_q;
    stage_d = stage_q;
    err_d   = err_q;
    resp_d  = 1'b0;
    rdata_d = '0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_read ^ bus.mem_write) begin
          idx_d   = bus.mem_addr[OFFSET_W +: IDX_W];
          is_wr_d = bus.mem_write;
          lat_d   = CNT_W'(LATENCY - 1);
          beat_d  = '0;
          state_d = WAIT;
        end else if (bus.mem_read && bus.mem_write) begin
          err_d = 1'b1;
        end
      end

      WAIT: begin
        if (req_dropped) begin
          err_d = 1'b1;
        end
        if (lat_q == '0) begin
          state_d = BURST;
          resp_d  = 1'b1;
          if (!is_wr_q) begin
            rdata_d = line_rd[0 +: BEAT_W];
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      BURST: begin
        if (req_dropped) begin
          err_d = 1'b1;
        end
        if (is_wr_q) begin
          stage_d[BEAT_W*beat_q +: BEAT_W] = bus.mem_wdata;
        end
        if (beat_q == 2'd3) begin
          mem_we  = is_wr_q;
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 2'd1;
          resp_d = 1'b1;
          if (!is_wr_q) begin
            rdata_d = line_rd[BEAT_W*beat_d +: BEAT_W];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All control state in one register bank; reset aborts any transaction
  // immediately, and since the commit is gated by state_q no line is
  // written once reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      is_wr_q <= 1'b0;
      stage_q <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      is_wr_q <= is_wr_d;
      stage_q <= stage_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;
  assign err           = err_q;

endmodule
